// File: rtl/scoreboard_pkg.sv
// Shared constants and state encoding for the scoreboard display path.
// Segment patterns are active-high, bit0 = segment a ... bit6 = segment g.
package scoreboard_pkg;

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    S_TENS = 2'd0,
    S_GAP1 = 2'd1,
    S_ONES = 2'd2,
    S_GAP2 = 2'd3
  } mux_state_e;

endpackage

// File: rtl/seg_mux_driver_if.sv
// Bundle between the dual 7-segment source and the digit multiplexer.
// The master drives the digit patterns and the slave drives the shared pin bus.
interface seg_mux_driver_if #(
  parameter int DWELL_LOG2 = 2
);
  logic [6:0]            seg_tens_i;
  logic [6:0]            seg_ones_i;
  logic                  blank_zero_i;
  logic [DWELL_LOG2-1:0] brightness_i;
  logic [6:0]            seg_o;
  logic [1:0]            dig_en_o;
  logic                  frame_start_o;

  modport master (
    output seg_tens_i, seg_ones_i, blank_zero_i, brightness_i,
    input  seg_o, dig_en_o, frame_start_o
  );

  modport slave (
    input  seg_tens_i, seg_ones_i, blank_zero_i, brightness_i,
    output seg_o, dig_en_o, frame_start_o
  );
endinterface

// File: rtl/seg_mux_driver.sv
// Time-multiplexes two 7-segment digits onto one segment bus with blanking gaps,
// dwell-slot PWM brightness and optional leading-zero suppression.
module seg_mux_driver
  import scoreboard_pkg::*;
#(
  parameter int DWELL_LOG2     = 2,
  parameter int GAP_CYC        = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk_1khz_i,
  input  logic              rst_i,
  seg_mux_driver_if.slave   bus
);

  localparam int DWELL = 1 << DWELL_LOG2;
  // Counter must hold both the dwell and the gap terminal values (gap <= 7).
  localparam int CW = (DWELL_LOG2 > 3) ? DWELL_LOG2 : 3;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  mux_state_e            state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [CW-1:0]         term;

  logic [6:0]            tens_snap_reg, ones_snap_reg;
  logic                  blank_snap_reg;
  logic [DWELL_LOG2-1:0] bright_snap_reg;

  logic                  frame_entry;
  logic [6:0]            tens_cur, ones_cur;
  logic                  blank_cur;
  logic [DWELL_LOG2-1:0] bright_cur;
  logic                  lit, suppress;

  logic [6:0]            seg_raw, seg_next, seg_reg;
  logic [1:0]            dig_raw, dig_next, dig_reg;
  logic                  fs_next, fs_reg;

  // State register, phase counter, frame snapshot and output pins.
  always_ff @(posedge clk_1khz_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= S_GAP2;
      cnt_reg         <= GAP_LAST;
      tens_snap_reg   <= SEG_OFF;
      ones_snap_reg   <= SEG_OFF;
      blank_snap_reg  <= 1'b0;
      bright_snap_reg <= '0;
      seg_reg         <= SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
      dig_reg         <= 2'b00 ^ {2{DIG_ACTIVE_LOW}};
      fs_reg          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      tens_snap_reg   <= tens_cur;
      ones_snap_reg   <= ones_cur;
      blank_snap_reg  <= blank_cur;
      bright_snap_reg <= bright_cur;
      seg_reg         <= seg_next;
      dig_reg         <= dig_next;
      fs_reg          <= fs_next;
    end
  end

  // Next-state and counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    term       = ((state_reg == S_TENS) || (state_reg == S_ONES)) ? DWELL_LAST : GAP_LAST;
    if (cnt_reg == term) begin
      cnt_next = '0;
      case (state_reg)
        S_TENS:  state_next = S_GAP1;
        S_GAP1:  state_next = S_ONES;
        S_ONES:  state_next = S_GAP2;
        default: state_next = S_TENS;
      endcase
    end
  end

  // Output decode works on the values the registers are about to take, so the
  // pins line up with state/cnt without a further pipeline stage.
  always_comb begin
    frame_entry = (state_next == S_TENS) && (state_reg != S_TENS);
    tens_cur    = frame_entry ? bus.seg_tens_i   : tens_snap_reg;
    ones_cur    = frame_entry ? bus.seg_ones_i   : ones_snap_reg;
    blank_cur   = frame_entry ? bus.blank_zero_i : blank_snap_reg;
    bright_cur  = frame_entry ? bus.brightness_i : bright_snap_reg;

    lit      = (cnt_next <= CW'(bright_cur));
    suppress = blank_cur && (tens_cur == SEG_ZERO);
    seg_raw  = SEG_OFF;
    dig_raw  = 2'b00;
    fs_next  = 1'b0;

    case (state_next)
      S_TENS: begin
        fs_next = (cnt_next == '0);
        if (lit && !suppress) begin
          dig_raw = 2'b10;
          seg_raw = tens_cur;
        end
      end
      S_ONES: begin
        if (lit) begin
          dig_raw = 2'b01;
          seg_raw = ones_cur;
        end
      end
      default: ;
    endcase

    seg_next = seg_raw ^ {7{SEG_ACTIVE_LOW}};
    dig_next = dig_raw ^ {2{DIG_ACTIVE_LOW}};
  end

  assign bus.seg_o         = seg_reg;
  assign bus.dig_en_o      = dig_reg;
  assign bus.frame_start_o = fs_reg;

endmodule

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
- Sits downstream of the scoreboard's dual 7-segment driver.
- Takes the two parallel 7-bit segment patterns (tens, ones) and time-multiplexes them onto one shared 7-bit segment bus plus two digit enables, freeing Tiny Tapeout output pins.
- Adds inter-digit blanking (anti-ghosting), 4-level brightness PWM, and optional leading-zero suppression.
- Samples both digits once per frame so the pair is always tear-free.

Parameters:
- DWELL_LOG2, 2, log2 of cycles each digit is shown (dwell = 4 cycles).
- GAP_CYC, 1, blank cycles after each digit (range 1..7).
- SEG_ACTIVE_LOW, 0, 1 = invert seg_o at the pin.
- DIG_ACTIVE_LOW, 0, 1 = invert dig_en_o at the pin.

Ports:
- clk_1khz_i  in  1  1 kHz system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- seg_tens_i  in  7  tens pattern, active-high, bit0 = segment a … bit6 = segment g.
- seg_ones_i  in  7  ones pattern, same encoding.
- blank_zero_i  in  1  1 = suppress the tens digit when it shows "0".
- brightness_i  in  DWELL_LOG2  on-cycles per dwell minus 1 (0 = dimmest, all-ones = full).
- seg_o  out  7  shared segment bus.
- dig_en_o  out  2  digit enables: [1] = tens, [0] = ones.
- frame_start_o  out  1  one-cycle pulse on the first tens cycle of each frame.

Behaviour:
- FSM states, cyclic: S_TENS (dwell cycles) -> S_GAP1 (GAP_CYC) -> S_ONES (dwell) -> S_GAP2 (GAP_CYC) -> S_TENS.
- Frame length = 2*(2^DWELL_LOG2 + GAP_CYC) cycles; 10 cycles with defaults.
- Phase counter cnt counts 0..len-1 within each state; the state advances when cnt hits its terminal value, and cnt resets to 0.
- Reset (async assert):
  - state = S_GAP2 with cnt at terminal; snapshots cleared.
  - seg_o = off, dig_en_o = off (both after polarity), frame_start_o = 0.
- First rising edge after reset release: enter S_TENS, cnt = 0.
- Snapshot: on every entry to S_TENS, register seg_tens_i, seg_ones_i, blank_zero_i and brightness_i into shadow registers. Input changes mid-frame are not visible until the next frame.
- All outputs are registered and reflect the current state/cnt (no extra latency beyond the state register).
- In S_TENS at cnt = d:
  - dig_en_o[1] on iff d <= brightness_snap and the tens digit is not suppressed.
  - seg_o = tens_snap when dig_en_o[1] is on, else all off.
  - dig_en_o[0] off.
- S_ONES: same rule using ones_snap and dig_en_o[0]. The ones digit is never suppressed.
- S_GAP1 / S_GAP2: seg_o off, both enables off.
- Suppression: tens digit is suppressed iff blank_zero_snap = 1 and tens_snap == SEG_ZERO (7'h3F).
- frame_start_o = 1 exactly in S_TENS with cnt = 0.
- Polarity is applied last: seg_o ^= {7{SEG_ACTIVE_LOW}}; dig_en_o ^= {2{DIG_ACTIVE_LOW}}. "Off" means the inactive level after polarity.
- Invariant: both dig_en_o bits are never active in the same cycle.
- Async reset mid-frame: outputs go to off immediately (no clock required); the sequence restarts at S_TENS.
- brightness_i at all-ones: the digit is lit for all 2^DWELL_LOG2 dwell cycles.

Decomposition:
- Shared package scoreboard_pkg:
  - SEG_ZERO = 7'h3F and SEG_OFF = 7'h00.
  - Digit-mux state encoding (2-bit: S_TENS=0, S_GAP1=1, S_ONES=2, S_GAP2=3).
- No sub-module. The FSM, counter, snapshot and output stage form one cohesive block.

Test Plan:
- Reset values: hold rst_i high for 3 cycles -> seg_o = 0, dig_en_o = 2'b00, frame_start_o = 0. Release -> next edge gives frame_start_o = 1 and dig_en_o = 2'b10.
- Full brightness: tens = 7'h06, ones = 7'h5B, brightness = 3 -> 10-cycle frame:
  - 4 cycles seg_o = 06, dig_en = 10;
  - 1 cycle 00 / 00;
  - 4 cycles 5B / 01;
  - 1 cycle 00 / 00.
- Dim: brightness = 0 -> each digit lit only at cnt = 0; 1 of 10 cycles per digit enabled, seg_o off otherwise.
- Leading zero: tens = 7'h3F, ones = 7'h66, blank_zero = 1 -> tens slot fully off, ones slot shows 66. Same inputs with blank_zero = 0 -> tens slot shows 3F.
- Snapshot: change seg_ones_i from 7'h06 to 7'h4F during the S_TENS dwell -> the ones slot of that frame shows 06; the next frame shows 4F.
- Async reset mid-S_ONES plus polarity build (SEG_ACTIVE_LOW = 1, DIG_ACTIVE_LOW = 1):
  - On the reset edge, with no clock: seg_o = 7'h7F and dig_en_o = 2'b11 immediately.
  - After release: frame restarts with frame_start_o and dig_en_o = 2'b01.
